// File: rtl/fib_term_buffer.sv
// fib_term_buffer: downstream stage of the Fibonacci generator.
// Owns the generator's active-low reset, captures a programmed number of
// terms into a FIFO and streams each term with its 0-based index.
// Optional feature macro: FIB_WRAP_DETECT_EN enables unsigned wrap-around
// detection (a captured term smaller than its predecessor ends the run and
// raises the sticky overflow flag). Without it, overflow_o is tied low.
//
// Stream handshake: a term transfers on every rising clk edge where
// m_valid_o && m_ready_i. While m_valid_o is high and m_ready_i is low, the
// term, its index and its last flag are held unchanged; m_valid_o never
// drops without a transfer except on reset.
module fib_term_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int IDX_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [IDX_WIDTH-1:0]  num_terms_i,
  input  logic [DATA_WIDTH-1:0] term_in_i,
  output logic                  gen_resetn_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic [IDX_WIDTH-1:0]  m_index_o,
  output logic                  m_last_o,
  output logic                  busy_o,
  output logic                  overflow_o,
  output logic                  overrun_o,
  output logic [1:0]            dbg_state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   num_q, num_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic                   overrun_q, overrun_d;

  // FIFO storage: one entry is {term, index, last}
  logic [DATA_WIDTH-1:0]  mem_data_q [DEPTH];
  logic [IDX_WIDTH-1:0]   mem_idx_q  [DEPTH];
  logic                   mem_last_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          count_q, count_d;

  logic                   push;
  logic                   pop;
  logic                   wr_last;
  logic                   space_ok;
  logic                   is_last;
  logic                   wrap;

  assign pop      = (count_q != '0) && m_ready_i;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign space_ok = (count_q < CW'(DEPTH)) || pop;
  assign is_last  = (idx_q == (num_q - IDX_WIDTH'(1)));

`ifdef FIB_WRAP_DETECT_EN
  logic [DATA_WIDTH-1:0]  prev_q, prev_d;
  logic                   overflow_q, overflow_d;

  // A Fibonacci term below its predecessor means the adder wrapped.
  assign wrap       = (idx_q != '0) && (term_in_i < prev_q);
  assign overflow_o = overflow_q;

  // Previous captured term and sticky overflow flag
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prev_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      overflow_q <= overflow_d;
    end
  end

  // Track the last accepted term; clear overflow on a new run, set on wrap
  always_comb begin
    prev_d     = prev_q;
    overflow_d = overflow_q;
    if (state_q == S_IDLE && start_i && num_terms_i != '0) begin
      overflow_d = 1'b0;
    end
    if (push) begin
      prev_d = term_in_i;
    end
    if (state_q == S_CAPTURE && space_ok && wrap) begin
      overflow_d = 1'b1;
    end
  end
`else
  assign wrap       = 1'b0;
  assign overflow_o = 1'b0;
`endif

  // Run-control state register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      num_q     <= '0;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state logic: start a run, capture one term per cycle, drain
  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    push      = 1'b0;
    wr_last   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i && num_terms_i != '0) begin
          num_d     = num_terms_i;
          idx_d     = '0;
          overrun_d = 1'b0;
          state_d   = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (space_ok) begin
          push  = 1'b1;
          idx_d = idx_q + IDX_WIDTH'(1);
          if (wrap || is_last) begin
            wr_last = 1'b1;
            state_d = S_DRAIN;
          end
        end else begin
          // Term lost: abort, deliver what is buffered, no final marker.
          overrun_d = 1'b1;
          state_d   = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (count_q == '0 || (count_q == CW'(1) && pop)) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO occupancy next value
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and occupancy; reset flushes the buffer
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  // FIFO storage write; contents are don't-care until counted valid
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= term_in_i;
      mem_idx_q[wr_ptr_q]  <= idx_q;
      mem_last_q[wr_ptr_q] <= wr_last;
    end
  end

  // Stream outputs come straight from the registered head entry
  always_comb begin
    m_valid_o = (count_q != '0);
    m_data_o  = '0;
    m_index_o = '0;
    m_last_o  = 1'b0;
    if (m_valid_o) begin
      m_data_o  = mem_data_q[rd_ptr_q];
      m_index_o = mem_idx_q[rd_ptr_q];
      m_last_o  = mem_last_q[rd_ptr_q];
    end
  end

  // The generator runs only while terms are being captured; otherwise it
  // is held at its 1,1 seed so the next run starts from term 0.
  assign gen_resetn_o = (state_q == S_CAPTURE);
  assign busy_o       = (state_q != S_IDLE);
  assign overrun_o    = overrun_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_fib_term_buffer.sv
// Directed bench for fib_term_buffer: two instances (32-bit/depth 8 and
// 8-bit/depth 16), each fed by a behavioural Fibonacci generator.
module tb_fib_term_buffer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: DATA_WIDTH=32, DEPTH=8
  logic        a_start, a_gen_resetn, a_valid, a_ready, a_last, a_busy, a_ovf, a_ovr;
  logic [7:0]  a_num, a_index;
  logic [31:0] a_term, a_data;
  logic [1:0]  a_state;

  // Instance B: DATA_WIDTH=8, DEPTH=16
  logic        b_start, b_gen_resetn, b_valid, b_ready, b_last, b_busy, b_ovf, b_ovr;
  logic [7:0]  b_num, b_index;
  logic [7:0]  b_term, b_data;
  logic [1:0]  b_state;

  fib_term_buffer #(.DATA_WIDTH(32), .DEPTH(8), .IDX_WIDTH(8)) u_a (
    .clk_i(clk), .reset_i(reset), .start_i(a_start), .num_terms_i(a_num),
    .term_in_i(a_term), .gen_resetn_o(a_gen_resetn), .m_valid_o(a_valid),
    .m_ready_i(a_ready), .m_data_o(a_data), .m_index_o(a_index),
    .m_last_o(a_last), .busy_o(a_busy), .overflow_o(a_ovf),
    .overrun_o(a_ovr), .dbg_state_o(a_state)
  );

  fib_term_buffer #(.DATA_WIDTH(8), .DEPTH(16), .IDX_WIDTH(8)) u_b (
    .clk_i(clk), .reset_i(reset), .start_i(b_start), .num_terms_i(b_num),
    .term_in_i(b_term), .gen_resetn_o(b_gen_resetn), .m_valid_o(b_valid),
    .m_ready_i(b_ready), .m_data_o(b_data), .m_index_o(b_index),
    .m_last_o(b_last), .busy_o(b_busy), .overflow_o(b_ovf),
    .overrun_o(b_ovr), .dbg_state_o(b_state)
  );

  // Behavioural generators: sync active-low reset to 1,1, then a<=b, b<=a+b
  logic [31:0] a_fa, a_fb;
  logic [7:0]  b_fa, b_fb;
  always @(posedge clk) begin
    if (!a_gen_resetn) begin
      a_fa <= 32'd1; a_fb <= 32'd1;
    end else begin
      a_fa <= a_fb;  a_fb <= a_fa + a_fb;
    end
    if (!b_gen_resetn) begin
      b_fa <= 8'd1; b_fb <= 8'd1;
    end else begin
      b_fa <= b_fb;  b_fb <= b_fa + b_fb;
    end
  end
  assign a_term = a_fa;
  assign b_term = b_fa;

  // Scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] got_a_data[$], got_a_idx[$], got_a_last[$];
  logic [31:0] got_b_data[$], got_b_idx[$], got_b_last[$];
  int tests  = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: record transfers, advance, then verify stalled heads held
  task automatic step();
    logic        hold_pend;
    logic [31:0] h_data;
    logic [7:0]  h_idx;
    logic        h_last;
    if (!reset && a_valid && a_ready) begin
      got_a_data.push_back(a_data);
      got_a_idx.push_back({24'd0, a_index});
      got_a_last.push_back({31'd0, a_last});
    end
    if (!reset && b_valid && b_ready) begin
      got_b_data.push_back({24'd0, b_data});
      got_b_idx.push_back({24'd0, b_index});
      got_b_last.push_back({31'd0, b_last});
    end
    hold_pend = !reset && a_valid && !a_ready;
    h_data = a_data; h_idx = a_index; h_last = a_last;
    @(posedge clk);
    #1;
    if (hold_pend) begin
      chk("hold_valid", {63'd0, a_valid}, 64'd1);
      chk("hold_data",  {32'd0, a_data}, {32'd0, h_data});
      chk("hold_index", {56'd0, a_index}, {56'd0, h_idx});
      chk("hold_last",  {63'd0, a_last}, {63'd0, h_last});
    end
  endtask

  task automatic clear_got();
    got_a_data.delete(); got_a_idx.delete(); got_a_last.delete();
    got_b_data.delete(); got_b_idx.delete(); got_b_last.delete();
  endtask

  // Step until the selected instance is idle, bounded by a cycle budget
  task automatic run_idle(input int which, input int budget);
    int n;
    n = 0;
    while (((which == 0) ? a_busy : b_busy) && n < budget) begin
      step();
      n++;
    end
    chk("idle_timeout", {63'd0, ((which == 0) ? a_busy : b_busy)}, 64'd0);
  endtask

  // Compare collected stream against exp_q; last_at < 0 means no m_last
  task automatic check_stream(input string tag, input int which, input int last_at);
    logic [31:0] gd[$], gi[$], gl[$];
    int n;
    if (which == 0) begin gd = got_a_data; gi = got_a_idx; gl = got_a_last; end
    else            begin gd = got_b_data; gi = got_b_idx; gl = got_b_last; end
    chk({tag, "_count"}, 64'(gd.size()), 64'(exp_q.size()));
    n = (gd.size() < exp_q.size()) ? gd.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_data"},  {32'd0, gd[i]}, {32'd0, exp_q[i]});
      chk({tag, "_index"}, {32'd0, gi[i]}, 64'(i));
      chk({tag, "_last"},  {32'd0, gl[i]}, (i == last_at) ? 64'd1 : 64'd0);
    end
  endtask

  task automatic start_a(input logic [7:0] n);
    a_start = 1'b1; a_num = n;
    step();
    a_start = 1'b0;
  endtask

  initial begin
    logic [31:0] fib8 [20];
    fib8 = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233,
             121, 98, 219, 61, 24, 85, 109};
    reset = 1'b1;
    a_start = 1'b0; a_num = 8'd0; a_ready = 1'b1;
    b_start = 1'b0; b_num = 8'd0; b_ready = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Reset state
    chk("rst_valid",  {63'd0, a_valid}, 64'd0);
    chk("rst_data",   {32'd0, a_data}, 64'd0);
    chk("rst_index",  {56'd0, a_index}, 64'd0);
    chk("rst_last",   {63'd0, a_last}, 64'd0);
    chk("rst_busy",   {63'd0, a_busy}, 64'd0);
    chk("rst_ovf",    {63'd0, a_ovf}, 64'd0);
    chk("rst_ovr",    {63'd0, a_ovr}, 64'd0);
    chk("rst_genrst", {63'd0, a_gen_resetn}, 64'd0);
    chk("rst_b_busy", {63'd0, b_busy}, 64'd0);

    // 1: five terms, consumer always ready
    clear_got();
    start_a(8'd5);
    chk("t1_busy", {63'd0, a_busy}, 64'd1);
    chk("t1_genrst", {63'd0, a_gen_resetn}, 64'd1);
    run_idle(0, 40);
    exp_q = '{1, 1, 2, 3, 5};
    check_stream("t1", 0, 4);
    chk("t1_ovf", {63'd0, a_ovf}, 64'd0);
    chk("t1_ovr", {63'd0, a_ovr}, 64'd0);

    // 2: twelve terms with consumer stalled: 8 held, 9th dropped
    clear_got();
    a_ready = 1'b0;
    start_a(8'd12);
    repeat (8) step();
    chk("t2_ovr_before", {63'd0, a_ovr}, 64'd0);
    step();
    chk("t2_ovr_set", {63'd0, a_ovr}, 64'd1);
    chk("t2_drain", {62'd0, a_state}, 64'd2);
    chk("t2_genrst", {63'd0, a_gen_resetn}, 64'd0);
    chk("t2_head_data", {32'd0, a_data}, 64'd1);
    chk("t2_head_idx", {56'd0, a_index}, 64'd0);
    step();
    a_ready = 1'b1;
    run_idle(0, 40);
    exp_q = '{1, 1, 2, 3, 5, 8, 13, 21};
    check_stream("t2", 0, -1);
    chk("t2_ovr_sticky", {63'd0, a_ovr}, 64'd1);
    chk("t2_valid_end", {63'd0, a_valid}, 64'd0);

    // 3: 8-bit instance, twenty terms, wrap at index 13
    clear_got();
    b_start = 1'b1; b_num = 8'd20;
    step();
    b_start = 1'b0;
    run_idle(1, 80);
    exp_q.delete();
`ifdef FIB_WRAP_DETECT_EN
    for (int i = 0; i < 14; i++) exp_q.push_back(fib8[i]);
    check_stream("t3", 1, 13);
    chk("t3_ovf", {63'd0, b_ovf}, 64'd1);
`else
    for (int i = 0; i < 20; i++) exp_q.push_back(fib8[i]);
    check_stream("t3", 1, 19);
    chk("t3_ovf", {63'd0, b_ovf}, 64'd0);
`endif
    chk("t3_ovr", {63'd0, b_ovr}, 64'd0);

    // 4: start during capture is ignored; num_terms=0 is ignored
    clear_got();
    start_a(8'd6);
    step();
    a_start = 1'b1; a_num = 8'd3;
    step();
    a_start = 1'b0;
    run_idle(0, 40);
    exp_q = '{1, 1, 2, 3, 5, 8};
    check_stream("t4", 0, 5);
    chk("t4_ovr_cleared", {63'd0, a_ovr}, 64'd0);
    start_a(8'd0);
    chk("t4_zero_busy", {63'd0, a_busy}, 64'd0);
    repeat (3) step();
    chk("t4_zero_valid", {63'd0, a_valid}, 64'd0);
    chk("t4_zero_busy2", {63'd0, a_busy}, 64'd0);

    // 5: reset after three delivered terms of a ten-term run
    clear_got();
    start_a(8'd10);
    for (int n = 0; n < 40 && got_a_data.size() < 3; n++) step();
    chk("t5_three", 64'(got_a_data.size()), 64'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_valid", {63'd0, a_valid}, 64'd0);
    chk("t5_busy", {63'd0, a_busy}, 64'd0);
    chk("t5_genrst", {63'd0, a_gen_resetn}, 64'd0);
    clear_got();
    start_a(8'd3);
    run_idle(0, 40);
    exp_q = '{1, 1, 2};
    check_stream("t5", 0, 2);

    // 6: consumer ready toggling each cycle
    clear_got();
    start_a(8'd6);
    for (int n = 0; n < 60 && a_busy; n++) begin
      a_ready = ~a_ready;
      step();
    end
    a_ready = 1'b1;
    chk("t6_idle", {63'd0, a_busy}, 64'd0);
    exp_q = '{1, 1, 2, 3, 5, 8};
    check_stream("t6", 0, 5);
    chk("t6_ovr", {63'd0, a_ovr}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
